// File: rtl/led_matrix_pwm.sv
// led_matrix_pwm: row-scanned LED matrix driver with per-pixel PWM grayscale,
// blanking at each row change, and a double-buffered frame input.
//
// Optional feature: define LEDM_GLOBAL_DIM_EN to add a global dim input
// that caps the number of lit PWM slots per row.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_data   DIM_X*DIM_Y*BPP pixels, pixel i=y*DIM_X+x at [i*BPP +: BPP]
//   frame_valid  frame_data valid
//   frame_ready  shadow buffer free; transfer on valid && ready
//   dim          (LEDM_GLOBAL_DIM_EN only) global brightness cap, sampled each tick
//   row          one-hot row drive, active high (registered)
//   col          column drive, active low (registered)
//   frame_start  one-clk pulse when the scan restarts at row 0
module led_matrix_pwm #(
    parameter int DIM_X       = 6,
    parameter int DIM_Y       = 6,
    parameter int BPP         = 4,
    parameter int PRESCALE    = 16,
    parameter int BLANK_SLOTS = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIM_X*DIM_Y*BPP-1:0] frame_data,
    input  logic                       frame_valid,
`ifdef LEDM_GLOBAL_DIM_EN
    input  logic [BPP-1:0]             dim,
`endif
    output logic                       frame_ready,
    output logic [DIM_Y-1:0]           row,
    output logic [DIM_X-1:0]           col,
    output logic                       frame_start
);

    localparam int SLOTS = BLANK_SLOTS + (1 << BPP) - 1;
    localparam int FW    = DIM_X * DIM_Y * BPP;
    localparam int PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW    = (SLOTS > 1)    ? $clog2(SLOTS)    : 1;
    localparam int RW    = (DIM_Y > 1)    ? $clog2(DIM_Y)    : 1;

    logic [PW-1:0]    pre_cnt;
    logic [SW-1:0]    slot;
    logic [RW-1:0]    row_idx;
    logic [FW-1:0]    active;
    logic [FW-1:0]    shadow;
    logic             pending;
    logic             tick;
    logic             row_end;
    logic             frame_end;
    logic [BPP-1:0]   dim_q;
    logic [DIM_Y-1:0] row_nxt;
    logic [DIM_X-1:0] col_nxt;
    logic [BPP-1:0]   pwm_p;
    logic [BPP-1:0]   pix;

    assign tick        = (pre_cnt == PW'(PRESCALE - 1));
    assign row_end     = tick && (slot == SW'(SLOTS - 1));
    assign frame_end   = row_end && (row_idx == RW'(DIM_Y - 1));
    assign frame_ready = !pending;

`ifdef LEDM_GLOBAL_DIM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dim_q <= '0;
        end else if (tick) begin
            dim_q <= dim;
        end
    end
`else
    // Without the dim port every PWM slot is allowed.
    assign dim_q = '1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            slot    <= '0;
            row_idx <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (row_end) begin
                slot    <= '0;
                row_idx <= (row_idx == RW'(DIM_Y - 1)) ? '0 : row_idx + 1'b1;
            end else if (tick) begin
                slot <= slot + 1'b1;
            end
        end
    end

    // Accept and swap are mutually exclusive: ready is low while pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (frame_valid && frame_ready) begin
            shadow  <= frame_data;
            pending <= 1'b1;
        end else if (frame_end && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

    // Slot p (after the blank slots) lights a pixel when value > p, so a
    // value v stays lit for exactly v slots.
    always_comb begin
        row_nxt = '0;
        col_nxt = '1;
        pwm_p   = '0;
        pix     = '0;
        if (slot >= SW'(BLANK_SLOTS)) begin
            pwm_p            = BPP'(slot - SW'(BLANK_SLOTS));
            row_nxt[row_idx] = 1'b1;
            for (int unsigned x = 0; x < DIM_X; x++) begin
                pix = active[(int'(row_idx) * DIM_X + int'(x)) * BPP +: BPP];
                if ((pix > pwm_p) && (pwm_p < dim_q)) begin
                    col_nxt[x] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row         <= '0;
            col         <= '1;
            frame_start <= 1'b0;
        end else begin
            row         <= row_nxt;
            col         <= col_nxt;
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_led_matrix_pwm.sv
// tb_led_matrix_pwm: scoreboard bench for led_matrix_pwm on a 2x2, BPP=2,
// PRESCALE=2, BLANK_SLOTS=1 configuration (8 clks/row, 16 clks/frame).
// The stimulus pushes the hand-computed per-pixel lit-clock counts of every
// accepted frame; the monitor gathers one frame of row/col samples after
// each frame_start and compares it with the popped expectation.
module tb_led_matrix_pwm;

    logic       clk;
    logic       rst_n;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       frame_ready;
    logic [1:0] row;
    logic [1:0] col;
    logic       frame_start;
`ifdef LEDM_GLOBAL_DIM_EN
    logic [1:0] dim;
`endif

    int errors;
    int checks;

    // Expected lit clocks per pixel, packed {p3,p2,p1,p0} as 8-bit counts.
    logic [31:0] exp_q[$];

    led_matrix_pwm #(
        .DIM_X      (2),
        .DIM_Y      (2),
        .BPP        (2),
        .PRESCALE   (2),
        .BLANK_SLOTS(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
`ifdef LEDM_GLOBAL_DIM_EN
        .dim        (dim),
`endif
        .frame_ready(frame_ready),
        .row        (row),
        .col        (col),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_fs(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    // Monitor / scoreboard
    initial begin
        int          cnt[4];
        int          blank_n;
        int          blank_bad;
        int          multi;
        int          order_bad;
        int          prev_y;
        int          samples;
        int          y;
        bit          collecting;
        logic [31:0] cur_exp;
        collecting = 1'b0;
        cur_exp    = '0;
        forever begin
            @(negedge clk);
            if (collecting && rst_n) begin
                samples++;
                if (row == 2'b00) begin
                    blank_n++;
                    if (col != 2'b11) blank_bad++;
                end else if (row == 2'b01 || row == 2'b10) begin
                    y = (row == 2'b01) ? 0 : 1;
                    if (y != prev_y) begin
                        if (y != prev_y + 1) order_bad++;
                        prev_y = y;
                    end
                    for (int x = 0; x < 2; x++) begin
                        if (col[x] == 1'b0) cnt[y*2+x]++;
                    end
                end else begin
                    multi++;
                end
            end
            if (frame_start) begin
                if (collecting) begin
                    for (int i = 0; i < 4; i++) begin
                        check($sformatf("pix%0d_lit_clks", i), cnt[i], int'(cur_exp[i*8 +: 8]));
                    end
                    check("frame_period", samples, 16);
                    check("blank_clks", blank_n, 4);
                    check("blank_col_lit", blank_bad, 0);
                    check("row_multi_hot", multi, 0);
                    check("row_order", (order_bad == 0 && prev_y == 1) ? 1 : 0, 1);
                end
                for (int i = 0; i < 4; i++) cnt[i] = 0;
                blank_n    = 0;
                blank_bad  = 0;
                multi      = 0;
                order_bad  = 0;
                prev_y     = -1;
                samples    = 0;
                collecting = 1'b1;
                if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            end
        end
    end

    // Stimulus
    initial begin
        int waited;
        bit taken;
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        frame_valid = 1'b1;
        frame_data  = 8'he4;                 // A: pixels (0,1,2,3)
`ifdef LEDM_GLOBAL_DIM_EN
        dim         = 2'd3;
`endif
        repeat (3) @(negedge clk);
        check("reset_row", int'(row), 0);
        check("reset_col", int'(col), 3);
        check("reset_ready", int'(frame_ready), 1);
        check("reset_frame_start", int'(frame_start), 0);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_accept_ready_low", int'(frame_ready), 0);
        frame_valid = 1'b0;
        exp_q.push_back({8'd6, 8'd4, 8'd2, 8'd0});

        wait_fs("fs1_timeout");
        check("ready_after_swap_A", int'(frame_ready), 1);
        wait_fs("fs2_timeout");

        // Offer B mid-frame.
        repeat (5) @(negedge clk);
        frame_data  = 8'h93;                 // B: pixels (3,0,1,2)
        frame_valid = 1'b1;
        check("ready_before_B", int'(frame_ready), 1);
        @(posedge clk);
        #1;
        check("ready_drop_after_B", int'(frame_ready), 0);
        exp_q.push_back({8'd4, 8'd2, 8'd0, 8'd6});

        // Offer C while B pending; it must wait for the swap.
        frame_data = 8'h3e;                  // C: pixels (2,3,3,0)
        waited     = 0;
        taken      = 1'b0;
        while (!taken && waited < 60) begin
            @(negedge clk);
            if (frame_ready) begin
                check("ready_return_with_frame_start", int'(frame_start), 1);
                taken = 1'b1;
            end else begin
                waited++;
            end
        end
        check("C_accepted_in_budget", int'(taken), 1);
        check("C_held_off", (waited >= 5) ? 1 : 0, 1);
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        check("ready_drop_after_C", int'(frame_ready), 0);
        exp_q.push_back({8'd0, 8'd6, 8'd6, 8'd4});

        wait_fs("fs4_timeout");
        wait_fs("fs5_timeout");
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_matrix_pwm.md
Name: led_matrix_pwm

Overview:
Parametrised successor to the 6x6 on/off LED FeatherWing driver. Scans a DIM_X x DIM_Y matrix one row at a time. Per-pixel grayscale comes from BPP-bit PWM within each row period. A blanking interval at each row change suppresses ghosting. A double-buffered frame input with a valid/ready handshake gives tear-free updates. Sits between the image source (pattern generator or host logic) and the matrix row/col pins.

Parameters:
DIM_X, 6, number of columns (col width)
DIM_Y, 6, number of rows (row width)
BPP, 4, grayscale bits per pixel; 2^BPP-1 PWM slots per row
PRESCALE, 16, clk cycles per PWM slot tick (>=1)
BLANK_SLOTS, 1, blank slot ticks at start of each row (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
frame_data  input  DIM_X*DIM_Y*BPP  pixel i=y*DIM_X+x at bits [i*BPP +: BPP]
frame_valid  input  1  frame_data valid
frame_ready  output  1  shadow buffer free; transfer when valid&&ready
row  output  DIM_Y  one-hot row drive, active high
col  output  DIM_X  column drive, active low (col[x] = column x)
frame_start  output  1  one-clk pulse when scan restarts at row 0

Behaviour:
- Reset (async assert, sync release) values:
  - pre_cnt=0, slot=0, row_idx=0
  - active buffer=0, shadow buffer=0, pending=0
  - row=0, col=all 1s, frame_start=0, frame_ready=1
- Prescaler: pre_cnt counts 0..PRESCALE-1. tick=1 in the cycle pre_cnt==PRESCALE-1, then pre_cnt wraps to 0.
- Slot counter: advances on tick over 0..S-1, where S=BLANK_SLOTS+2^BPP-1.
  - Slots 0..BLANK_SLOTS-1 are blank: row=0, col=all 1s.
  - Slot BLANK_SLOTS+p, p=0..2^BPP-2: row[row_idx]=1, col[x]=0 iff active pixel(x,row_idx) > p.
  - Value 0 is never lit. Value 2^BPP-1 is lit in all PWM slots. Value v is lit for v slots.
- Row advance: on tick with slot==S-1:
  - slot->0.
  - row_idx increments, wrapping DIM_Y-1 -> 0.
- Frame boundary (the tick where row_idx wraps to 0):
  - If pending=1: active<=shadow, pending<=0.
  - frame_start pulses exactly that cycle.
  - Mid-frame shadow writes never touch the active buffer.
- Handshake:
  - frame_ready = !pending (combinational).
  - On valid&&ready: shadow<=frame_data, pending<=1.
  - A swap and an accept can never coincide, because ready is low while pending. ready returns high the cycle after the swap.
  - A second frame offered while pending waits; the source holds data until accepted.
- Outputs row/col are registered: they reflect the counter state with 1 clk latency.
- Timing:
  - Row period = S*PRESCALE clks. Frame period = DIM_Y*S*PRESCALE clks.
  - Defaults: 256 clks/row, 1536 clks/frame.
- Reset mid-operation: all state returns to reset values immediately. Any pending frame is discarded. Outputs blank at once.
- Widths: counters sized by $clog2 of their ranges (min 1 bit). Comparison is unsigned BPP-bit.

Optional Feature:
Macro LEDM_GLOBAL_DIM_EN.
- Defined: adds input port dim [BPP-1:0], sampled each tick.
  - A PWM slot p is lit only if p < dim and pixel > p. Pixel brightness becomes min(v,dim) slots.
  - dim=0 blanks the display. dim=2^BPP-1 gives full brightness.
- Undefined: no dim port; behaviour as if dim=2^BPP-1.

Test Plan:
- Reset: hold rst_n=0 with frame_valid=1 -> row=0, col=6'b111111, frame_ready=1, frame_start=0. After release, first accept occurs on the next cycle.
- Grayscale, DIM 2x2, BPP=2, PRESCALE=2, BLANK_SLOTS=1, pixels (0,1,2,3) -> row 0: first 2 clks blank, then col[0] never low, col[1] low 2 clks. Row 1: col[0] low 4 clks, col[1] low 6 clks. Row period 8 clks.
- Double buffer: accept frame A, wait one frame, then offer B mid-frame -> ready drops one clk after accept. Display keeps A until the row wrap. frame_start coincides with the swap to B. ready re-asserts the next clk.
- Back-pressure: offer C while B pending -> C not accepted until after the swap. Exactly one accept per frame boundary.
- Blanking/one-hot: over a full frame, row is never multi-hot. row=0 and col=all 1s during every blank slot. Rows are visited 0..DIM_Y-1 and wrap to 0.
- LEDM_GLOBAL_DIM_EN with dim=1 and pixel value 3 (BPP=2) -> lit 1 slot per row. dim=0 -> col stays all 1s.
